// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers line/frame timing from raw VGA syncs and produces
// lock status, active-window data enable and pixel coordinates.
module vga_sync_decoder #(
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   H_START    = 144,
    parameter int   H_ACTIVE   = 640,
    parameter int   V_START    = 35,
    parameter int   V_ACTIVE   = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic        locked,
    output logic        frame_start,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
    localparam logic [10:0] H_BEG = 11'(H_START);
    localparam logic [10:0] H_END = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_BEG = 10'(V_START);
    localparam logic [9:0]  V_END = 10'(V_START + V_ACTIVE);
    state_t      state_q, state_d;
    logic [2:0]  hs_q, vs_q;
    logic [10:0] hcount_q, hcount_d, hcount_inc, line_len_q, line_len_d;
    logic [9:0]  vcount_q, vcount_d, vcount_inc, frame_lines_q, frame_lines_d;
    logic        mismatch_q, mismatch_d, frame_start_q, frame_start_d;
    logic        h_edge, v_edge, line_mm, frame_mm, overflow;

    // bits [1:0] synchronize, bit [2] is the previous synced value
    assign h_edge = (hs_q[1] == H_SYNC_POL) && (hs_q[2] != H_SYNC_POL);
    assign v_edge = (vs_q[1] == V_SYNC_POL) && (vs_q[2] != V_SYNC_POL);

    always_comb begin
        hcount_inc    = &hcount_q ? hcount_q : hcount_q + 11'd1;
        vcount_inc    = &vcount_q ? vcount_q : vcount_q + 10'd1;
        hcount_d      = h_edge ? 11'd0 : hcount_inc;
        line_len_d    = h_edge ? hcount_inc : line_len_q;
        vcount_d      = v_edge ? 10'd0 : h_edge ? vcount_inc : vcount_q;
        frame_lines_d = v_edge ? vcount_inc : frame_lines_q;
        line_mm       = h_edge && (line_len_d != line_len_q);
        frame_mm      = v_edge && (frame_lines_d != frame_lines_q);
        overflow      = &hcount_d || &vcount_d;
        mismatch_d    = v_edge ? 1'b0 : mismatch_q || line_mm;
        state_d       = state_q;
        case (state_q)
            IDLE:    state_d = v_edge ? ACQUIRE : IDLE;
            ACQUIRE: state_d = overflow ? IDLE :
                               (v_edge && !frame_mm && !line_mm && !mismatch_q) ? LOCKED : ACQUIRE;
            LOCKED:  state_d = (overflow || line_mm || frame_mm) ? IDLE : LOCKED;
            default: state_d = IDLE;
        endcase
        // an edge counts as "in LOCKED" if we were locked or are locking on it
        frame_start_d = v_edge && (state_q == LOCKED || state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q          <= {3{~H_SYNC_POL}};
            vs_q          <= {3{~V_SYNC_POL}};
            state_q       <= IDLE;
            hcount_q      <= '0;
            vcount_q      <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            mismatch_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hs_q          <= {hs_q[1:0], hsync_in};
            vs_q          <= {vs_q[1:0], vsync_in};
            state_q       <= state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            mismatch_q    <= mismatch_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign locked      = state_q == LOCKED;
    assign de          = locked && hcount_q >= H_BEG && hcount_q < H_END &&
                         vcount_q >= V_BEG && vcount_q < V_END;
    assign x           = de ? hcount_q[9:0] - H_BEG[9:0] : '0;
    assign y           = de ? vcount_q - V_BEG : '0;
    assign frame_start = frame_start_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of sync measurement, lock, de window,
// fault recovery, sync polarity and reset, using an 800-cycle line and 8-line frame.
module tb_vga_sync_decoder;
    localparam int LINE = 800, LINES = 8, HS_W = 96, NT = 60000;
    logic clk = 1'b0, rst_n = 1'b0, hs = 1'b1, vs = 1'b1;
    logic [9:0]  x_a, y_a, fl_a, x_b, y_b, fl_b;
    logic [10:0] ll_a, ll_b;
    logic        de_a, lk_a, fs_a, de_b, lk_b, fs_b, hold = 1'b0;
    logic        lk_log_a [NT];
    logic        lk_log_b [NT];
    logic        fs_log_a [NT];
    int n_checks = 0, n_fail = 0;
    int hp = 0, vl = 0, fr = 1, tk = 0, ph1 = 0, ph2 = 0, pv1 = 0, pv2 = 0;
    int tk_line = 0, tk_inj = 0, tk_ref = 0, tk_rel = 0, k = 0;
    int de_n_a = 0, de_n_b = 0, fs_n_a = 0, fs_n_b = 0, bad_de = 0, diff_n = 0, xy_err = 0;
    int fx = -1, fy = -1, fh = -1, fv = -1, lx = -1, ly = -1;
    bit seen = 1'b0;
    int tk_vs [$];

    always #5 clk = ~clk;

    vga_sync_decoder #(.V_START(2), .V_ACTIVE(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .hsync_in(hs), .vsync_in(vs),
        .x(x_a), .y(y_a), .de(de_a), .locked(lk_a), .frame_start(fs_a),
        .line_len(ll_a), .frame_lines(fl_a)
    );

    vga_sync_decoder #(.H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .V_START(2), .V_ACTIVE(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .hsync_in(~hs), .vsync_in(~vs),
        .x(x_b), .y(y_b), .de(de_b), .locked(lk_b), .frame_start(fs_b),
        .line_len(ll_b), .frame_lines(fl_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one pixel of the active-low stream; frame 5 line 3 is one cycle short
    task automatic tick();
        int len;
        len = (fr == 5 && vl == 3) ? LINE - 1 : LINE;
        if (hold) begin
            hs = 1'b1;
            vs = 1'b1;
        end else begin
            hs = hp < HS_W ? 1'b0 : 1'b1;
            vs = vl == 0 ? 1'b0 : 1'b1;
            if (hp == 0) tk_line = tk;
            if (hp == 0 && vl == 0) tk_vs.push_back(tk);
            if (hp == 0 && vl == 4 && fr == 5) tk_inj = tk;
        end
        @(posedge clk);
        #1;
        if (tk < NT) begin
            lk_log_a[tk] = lk_a;
            lk_log_b[tk] = lk_b;
            fs_log_a[tk] = fs_a;
        end
        fs_n_a += int'(fs_a);
        fs_n_b += int'(fs_b);
        if (de_a && !lk_a) bad_de++;
        if ({x_a, y_a, de_a, lk_a, fs_a, ll_a, fl_a} !== {x_b, y_b, de_b, lk_b, fs_b, ll_b, fl_b}) diff_n++;
        if (fr == 4 && !hold) begin
            de_n_b += int'(de_b);
            if (de_a) begin
                de_n_a++;
                if (!seen) begin
                    seen = 1'b1;
                    fx = int'(x_a); fy = int'(y_a); fh = ph2; fv = pv2;
                end
                lx = int'(x_a);
                ly = int'(y_a);
                if (int'(x_a) != ph2 - 144 || int'(y_a) != pv2 - 2) xy_err++;
            end
        end
        // the DUT lags the driven pixel by two synchronizer stages
        ph2 = ph1; pv2 = pv1; ph1 = hp; pv1 = vl;
        if (!hold) begin
            if (hp == len - 1) begin
                hp = 0;
                if (vl == LINES - 1) begin
                    vl = 0;
                    fr++;
                end else vl++;
            end else hp++;
        end
        tk++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state_a", {x_a, y_a, de_a, lk_a, fs_a, ll_a, fl_a}, 64'd0);
        check_eq("reset_state_b", {x_b, y_b, de_b, lk_b, fs_b, ll_b, fl_b}, 64'd0);
        rst_n = 1'b1;
        while (fr < 5) tick();
        check_eq("line_len_800", ll_a, 800);
        check_eq("frame_lines_8", fl_a, 8);
        check_eq("de_count_a", de_n_a, 3200);
        check_eq("de_count_b", de_n_b, 3200);
        check_eq("first_de_x", fx, 0);
        check_eq("first_de_y", fy, 0);
        check_eq("first_de_hcount", fh, 144);
        check_eq("first_de_vcount", fv, 2);
        check_eq("last_de_x", lx, 639);
        check_eq("last_de_y", ly, 4);
        check_eq("xy_tracking", xy_err, 0);
        while (!(fr == 7 && vl == 3)) tick();
        check_eq("locked_before_hold", lk_a, 1);
        tk_ref = tk_line;
        hold = 1'b1;
        repeat (2300) tick();
        check_eq("hold_line_len", ll_a, 800);
        hold = 1'b0;
        repeat (50) tick();
        check_eq("line_len_saturated", ll_a, 2047);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset_a", {x_a, y_a, de_a, lk_a, fs_a, ll_a, fl_a}, 64'd0);
        check_eq("async_reset_b", {x_b, y_b, de_b, lk_b, fs_b, ll_b, fl_b}, 64'd0);
        repeat (900) tick();
        check_eq("held_in_reset", {lk_a, ll_a, fl_a, lk_b, ll_b}, 64'd0);
        rst_n = 1'b1;
        tk_rel = tk;
        repeat (5) tick();
        check_eq("no_edge_from_reset_a", ll_a, 0);
        check_eq("no_edge_from_reset_b", ll_b, 0);
        while (!(vl == 5 && hp == 0)) tick();
        k = tk;
        repeat (3) tick();
        check_eq("count_from_reset", ll_a, k - tk_rel + 3);
        check_eq("lock_pre_v3", lk_log_a[tk_vs[2] + 1], 0);
        check_eq("lock_at_v3", lk_log_a[tk_vs[2] + 2], 1);
        check_eq("fs_at_v3", fs_log_a[tk_vs[2] + 2], 1);
        check_eq("fs_after_v3", fs_log_a[tk_vs[2] + 3], 0);
        check_eq("lock_pre_v3_b", lk_log_b[tk_vs[2] + 1], 0);
        check_eq("lock_at_v3_b", lk_log_b[tk_vs[2] + 2], 1);
        check_eq("inject_still_locked", lk_log_a[tk_inj + 1], 1);
        check_eq("inject_unlock", lk_log_a[tk_inj + 2], 0);
        check_eq("relock_not_v6", lk_log_a[tk_vs[5] + 2], 0);
        check_eq("relock_pre_v7", lk_log_a[tk_vs[6] + 1], 0);
        check_eq("relock_at_v7", lk_log_a[tk_vs[6] + 2], 1);
        check_eq("fs_at_v7", fs_log_a[tk_vs[6] + 2], 1);
        check_eq("hold_locked_2046", lk_log_a[tk_ref + 2048], 1);
        check_eq("hold_unlock_2047", lk_log_a[tk_ref + 2049], 0);
        check_eq("frame_start_count_a", fs_n_a, 4);
        check_eq("frame_start_count_b", fs_n_b, 4);
        check_eq("de_only_when_locked", bad_de, 0);
        check_eq("polarity_equivalence", diff_n, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_SYNC_POL, default 0, meaning hsync asserted level (0 = active-low).
REQ-002 SHALL have parameter V_SYNC_POL, default 0, meaning vsync asserted level (0 = active-low).
REQ-003 SHALL have parameter H_START, default 144, meaning hcount value of the first active pixel.
REQ-004 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-005 SHALL have parameter V_START, default 35, meaning vcount value of the first active line.
REQ-006 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-007 SHALL have ports:
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- hsync_in  in  1  raw horizontal sync, asynchronous to clk
- vsync_in  in  1  raw vertical sync, asynchronous to clk
- x  out  10  active pixel column
- y  out  10  active pixel row
- de  out  1  data enable; high inside the active window while locked
- locked  out  1  timing lock status
- frame_start  out  1  one-cycle pulse at each vsync leading edge while locked
- line_len  out  11  last measured line length in clk cycles
- frame_lines  out  10  last measured lines per frame

Function
REQ-008 SHALL pass each sync input through two synchronizer flops plus one history flop; leading edge = synced value at asserted level AND history value not asserted.
REQ-009 SHALL reset hcount (11 bits) to 0 on an hsync leading edge, else increment, saturating at 2047.
REQ-010 SHALL on an hsync leading edge load line_len with hcount+1, saturating at 2047.
REQ-011 SHALL increment vcount (10 bits) on each hsync leading edge, saturating at 1023.
REQ-012 SHALL on a vsync leading edge set vcount to 0 and load frame_lines with vcount+1; vsync takes priority when both edges coincide.
REQ-013 SHALL implement FSM states IDLE, ACQUIRE, LOCKED; locked high only in LOCKED.
REQ-014 SHALL transition IDLE->ACQUIRE on a vsync leading edge; clear line-mismatch flag.
REQ-015 SHALL set line-mismatch flag on any hsync leading edge whose new line_len differs from previous line_len; flag clears on every vsync leading edge.
REQ-016 SHALL transition ACQUIRE->LOCKED on a vsync leading edge when the new frame_lines equals the previous frame_lines and the line-mismatch flag is clear.
REQ-017 SHALL transition LOCKED->IDLE on a line_len mismatch, a frame_lines mismatch, hcount reaching 2047, or vcount reaching 1023.
REQ-018 SHALL transition ACQUIRE->IDLE on hcount reaching 2047 or vcount reaching 1023.
REQ-019 SHALL drive de combinationally from registered state/counters: locked AND H_START <= hcount < H_START+H_ACTIVE AND V_START <= vcount < V_START+V_ACTIVE.
REQ-020 SHALL drive x = hcount-H_START and y = vcount-V_START while de is high, else 0 for both.
REQ-021 SHALL register frame_start high for exactly the cycle after a vsync leading edge that occurs in LOCKED (including the edge that enters LOCKED).
REQ-022 SHALL make de drop in the same cycle locked drops.

Reset
REQ-023 SHALL on rst_n low immediately force: state IDLE, hcount 0, vcount 0, line_len 0, frame_lines 0, synchronizer and history flops to the deasserted sync level, all outputs 0.
REQ-024 SHALL resume counting from reset values on the first rising edge after rst_n rises; no edge SHALL be detected from the reset sync level.

Verification
REQ-025 Reset: rst_n low mid-frame with syncs toggling -> all outputs 0 without a clock edge, locked 0.
REQ-026 Standard 640x480 (800x525, active-low syncs) for 3 frames -> line_len=800, frame_lines=525, locked and frame_start rise at third vsync leading edge.
REQ-027 Locked 640x480 -> first de cycle x=0,y=0 at hcount=144,vcount=35; last de cycle x=639,y=479; exactly 307200 de cycles per frame.
REQ-028 Locked, inject one 799-cycle line -> locked and de 0 the cycle after that hsync edge; relock at the second subsequent vsync edge plus one (3 vsync edges total).
REQ-029 Locked, hold hsync deasserted -> locked drops when hcount reaches 2047; line_len unchanged.
REQ-030 H_SYNC_POL=1,V_SYNC_POL=1 with inverted syncs -> identical lock/de behaviour to REQ-026/REQ-027.
